// File: rtl/cache_pkg.sv
// Shared types and default geometry for the direct-mapped write-back data cache.
package cache_pkg;

    localparam int DEF_NUM_LINES      = 64;
    localparam int DEF_WORDS_PER_LINE = 4;

    localparam int OFF_W = $clog2(DEF_WORDS_PER_LINE);
    localparam int IDX_W = $clog2(DEF_NUM_LINES);
    localparam int TAG_W = 30 - OFF_W - IDX_W;

    // Smallest legal geometry (2 lines x 2 words) leaves 28 tag bits, so the
    // metadata tag field is sized for that and zero-extended for larger caches.
    localparam int MAX_TAG_W = 28;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } state_t;

    typedef struct packed {
        logic                 valid;
        logic                 dirty;
        logic [MAX_TAG_W-1:0] tag;
    } line_meta_t;

endpackage

// File: rtl/cache_data_array.sv
// Word storage for all cache lines: one combinational read port, one synchronous write port.
module cache_data_array #(
    parameter int NUM_LINES      = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                              clk,
    input  logic                              i_we,
    input  logic [$clog2(NUM_LINES)-1:0]      i_widx,
    input  logic [$clog2(WORDS_PER_LINE)-1:0] i_wword,
    input  logic [31:0]                       i_wdata,
    input  logic [$clog2(NUM_LINES)-1:0]      i_ridx,
    input  logic [$clog2(WORDS_PER_LINE)-1:0] i_rword,
    output logic [31:0]                       o_rdata
);

    logic [31:0] r_mem [NUM_LINES*WORDS_PER_LINE];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[{i_widx, i_wword}] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[{i_ridx, i_rword}];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache with a beat-oriented
// request/acknowledge memory port; hit is combinational in IDLE.
module data_cache
    import cache_pkg::*;
#(
    parameter int NUM_LINES      = DEF_NUM_LINES,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        hit,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output state_t      dbg_state
);

    localparam int OFF_BITS = $clog2(WORDS_PER_LINE);
    localparam int IDX_BITS = $clog2(NUM_LINES);
    localparam int TAG_BITS = 30 - OFF_BITS - IDX_BITS;
    localparam logic [OFF_BITS-1:0] LAST_BEAT = OFF_BITS'(WORDS_PER_LINE - 1);

    state_t                r_state;
    state_t                w_next_state;
    logic [OFF_BITS-1:0]   r_beat;
    line_meta_t            r_meta [NUM_LINES];
    logic [IDX_BITS-1:0]   r_miss_idx;
    logic [TAG_BITS-1:0]   r_miss_tag;

    logic [OFF_BITS-1:0]   w_off;
    logic [IDX_BITS-1:0]   w_idx;
    logic [TAG_BITS-1:0]   w_tag;
    line_meta_t            w_meta;
    logic                  w_req;
    logic                  w_lookup_hit;
    logic                  w_is_idle;
    logic                  w_last;
    logic                  w_miss;
    logic                  w_unused_addr_lsbs;

    logic                  w_arr_we;
    logic [IDX_BITS-1:0]   w_arr_widx;
    logic [OFF_BITS-1:0]   w_arr_wword;
    logic [31:0]           w_arr_wdata;
    logic [IDX_BITS-1:0]   w_rd_idx;
    logic [OFF_BITS-1:0]   w_rd_word;
    logic [31:0]           w_arr_rdata;

    assign w_off              = addr[OFF_BITS+1:2];
    assign w_idx              = addr[OFF_BITS+IDX_BITS+1:OFF_BITS+2];
    assign w_tag              = addr[31:OFF_BITS+IDX_BITS+2];
    assign w_unused_addr_lsbs = ^addr[1:0];
    assign w_meta             = r_meta[w_idx];
    assign w_req              = req_rd | req_wr;
    assign w_lookup_hit       = w_req & w_meta.valid & (w_meta.tag == MAX_TAG_W'(w_tag));
    assign w_is_idle          = (r_state == IDLE);
    assign w_miss             = w_is_idle & w_req & ~w_lookup_hit;
    assign w_last             = (r_beat == LAST_BEAT);
    assign dbg_state          = r_state;

    // Read port follows the request in IDLE and the victim beat during writeback.
    assign w_rd_idx  = w_is_idle ? w_idx : r_miss_idx;
    assign w_rd_word = w_is_idle ? w_off : r_beat;

    cache_data_array #(
        .NUM_LINES      (NUM_LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_data_array (
        .clk     (clk),
        .i_we    (w_arr_we),
        .i_widx  (w_arr_widx),
        .i_wword (w_arr_wword),
        .i_wdata (w_arr_wdata),
        .i_ridx  (w_rd_idx),
        .i_rword (w_rd_word),
        .o_rdata (w_arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        hit          = 1'b0;
        rdata        = 32'h0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = 32'h0;
        mem_wdata    = 32'h0;
        w_arr_we     = 1'b0;
        w_arr_widx   = w_idx;
        w_arr_wword  = w_off;
        w_arr_wdata  = wdata;
        unique case (r_state)
            IDLE: begin
                hit      = w_lookup_hit;
                rdata    = (w_lookup_hit & req_rd) ? w_arr_rdata : 32'h0;
                w_arr_we = w_lookup_hit & req_wr;
                if (w_miss) begin
                    w_next_state = (w_meta.valid & w_meta.dirty) ? WRITEBACK : FILL;
                end
            end
            WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = (32'(r_meta[r_miss_idx].tag) << (IDX_BITS + OFF_BITS + 2))
                          | 32'({r_miss_idx, r_beat, 2'b00});
                mem_wdata = w_arr_rdata;
                if (mem_ack && w_last) begin
                    w_next_state = FILL;
                end
            end
            FILL: begin
                mem_req     = 1'b1;
                mem_addr    = {r_miss_tag, r_miss_idx, r_beat, 2'b00};
                w_arr_we    = mem_ack;
                w_arr_widx  = r_miss_idx;
                w_arr_wword = r_beat;
                w_arr_wdata = mem_rdata;
                if (mem_ack && w_last) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Beat counter wraps to zero after the last beat, so FILL always starts at word 0.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_beat <= '0;
            for (int i = 0; i < NUM_LINES; i++) begin
                r_meta[i].valid <= 1'b0;
                r_meta[i].dirty <= 1'b0;
            end
        end else begin
            if (!w_is_idle && mem_ack) begin
                r_beat <= r_beat + 1'b1;
            end
            if (w_miss) begin
                r_miss_idx <= w_idx;
                r_miss_tag <= w_tag;
            end
            if (w_is_idle && w_lookup_hit && req_wr) begin
                r_meta[w_idx].dirty <= 1'b1;
            end
            if (r_state == FILL && mem_ack && w_last) begin
                r_meta[r_miss_idx].valid <= 1'b1;
                r_meta[r_miss_idx].dirty <= 1'b0;
                r_meta[r_miss_idx].tag   <= MAX_TAG_W'(r_miss_tag);
            end
        end
    end

endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-back, write-allocate data cache between the datapath's load/store port and main memory. It produces the `hit` signal the control unit uses to gate `pc_we` on LW/SW. On a miss it holds `hit` low, writes back a dirty victim line if needed, refills the line word by word over a request/acknowledge memory port, and then serves the access.

## Interface
Parameters:
- `NUM_LINES`, 64: number of lines; power of two, ≥2.
- `WORDS_PER_LINE`, 4: 32-bit words per line; power of two, ≥2.

Ports:
- `clk` input 1: the single clock; all state updates on rising edge.
- `rst_b` input 1: synchronous, active-low reset.
- `req_rd` input 1: LW in progress; held stable by the processor while `hit`=0.
- `req_wr` input 1: SW in progress; same rule. Never asserted together with `req_rd`.
- `addr` input 32: byte address; `[1:0]` ignored.
- `wdata` input 32: store data.
- `rdata` output 32: load data; valid when `hit`=1 and `req_rd`=1.
- `hit` output 1: request serviced this cycle.
- `mem_req` output 1: memory beat request.
- `mem_we` output 1: 1 = write beat, 0 = read beat.
- `mem_addr` output 32: word-aligned beat address.
- `mem_wdata` output 32: write-beat data.
- `mem_rdata` input 32: read-beat data, valid while `mem_ack`=1.
- `mem_ack` input 1: completes the current beat; may come in the same cycle as `mem_req`.

## Operation
- Address split: offset `addr[OFF+1:2]` (OFF = log2 WORDS_PER_LINE); index is the next log2 NUM_LINES bits; tag is the rest. With the defaults: index `addr[9:4]`, tag `addr[31:10]`.
- Per line: valid bit, dirty bit, tag, and WORDS_PER_LINE data words.
- FSM states:
  - IDLE: serves requests.
    - `hit` = (`req_rd`|`req_wr`) & valid[idx] & tag match.
    - Load hit: `rdata` comes combinationally from the array.
    - Store hit: word written and dirty[idx] set at that edge.
    - Miss with dirty victim: go to WRITEBACK.
    - Miss with clean or invalid victim: go to FILL.
    - No request: `hit`=0, state stays IDLE.
  - WRITEBACK:
    - `mem_req`=1, `mem_we`=1.
    - `mem_addr` = {stored tag, idx, beat, 2'b00}; `mem_wdata` = stored word[beat].
    - Beat counter advances on each `mem_ack`.
    - After the last ack: go to FILL with the counter cleared.
  - FILL:
    - `mem_req`=1, `mem_we`=0.
    - `mem_addr` = {req tag, idx, beat, 2'b00}; `mem_rdata` is written to word[beat] on each ack.
    - On the last ack: set valid, set tag, clear dirty, go to IDLE.
- After FILL, the access hits in IDLE on the following cycle. A store miss therefore writes its word and sets dirty in that hit cycle.
- Once started, WRITEBACK and FILL run to completion even if the request is deasserted.
- `hit`=0 in every state other than IDLE.
- `mem_req` and `mem_we` are 0 in IDLE.
- Reset values:
  - state = IDLE, beat counter = 0.
  - All valid and dirty bits = 0; data and tags are not reset.
  - `hit`=0, `mem_req`=0, `mem_we`=0; `mem_addr`, `mem_wdata` and `rdata` are 0.
- Reset mid-operation: the transaction is abandoned and `mem_req`=0 from the next cycle. All lines become invalid; dirty data is lost.

## Timing
- Hits have zero latency: `hit` is combinational from the request in the same cycle. Loads and stores complete at that edge.
- Beat rule: `mem_addr`, `mem_we` and `mem_wdata` stay stable while `mem_req`=1 and `mem_ack`=0. Each cycle with `mem_ack`=1 completes exactly one beat. `mem_req` may stay high across consecutive beats.
- Miss penalty with zero-wait memory (ack in the same cycle as request):
  - Clean miss: `hit` at cycle 1+W+1 after the request is first presented. With W=4: `hit`=1 in cycle 5 (cycle 0 = miss detect).
  - Dirty miss: W more cycles. With W=4: `hit` in cycle 9.
- Each extra wait cycle on a beat adds one cycle to the penalty.

## Structure
- `cache_pkg` holds:
  - the state enum (IDLE, WRITEBACK, FILL);
  - localparams for OFF/IDX/TAG widths derived from NUM_LINES and WORDS_PER_LINE;
  - a line-metadata struct (valid, dirty, tag).
- One sub-module, `cache_data_array`: word storage with one combinational read port (indexed by idx and word). It has one synchronous write port, shared by store hits and fill beats.
- The FSM, beat counter and metadata live in `data_cache`.

## Test plan
- Cold load: after reset, LW 0x100 with memory returning 0xA0..0xA3.
  - Read beats go to 0x100, 0x104, 0x108, 0x10C with `mem_we`=0.
  - `hit`=1 in cycle 5 with `rdata`=0xA0.
  - A following LW 0x108 hits immediately with `rdata`=0xA2 and `mem_req`=0.
- Store hit: SW 0x104 with 0xDEADBEEF gives `hit`=1 in the same cycle. A following LW 0x104 returns 0xDEADBEEF with no memory traffic.
- Dirty conflict: after the store above, LW 0x500 (same index 0x10).
  - Write beats go to 0x100..0x10C with `mem_wdata` = 0xA0, 0xDEADBEEF, 0xA2, 0xA3.
  - Then read beats go to 0x500..0x50C.
  - `hit` arrives in cycle 9; a later LW 0x100 misses again.
- Slow memory: `mem_ack` arrives 3 cycles after each beat starts. `mem_req`, `mem_addr` and `mem_we` hold stable, `hit` stays 0, and a clean miss takes 1+4×3+1 cycles.
- Reset during the second FILL beat: `mem_req`=0 the next cycle. A following LW 0x100 misses and refills from 0x100.
- Idle: `req_rd`=`req_wr`=0 for 10 cycles gives `hit`=0, `mem_req`=0, and no state change.
